daes_key_sched: RTL and testbench



---
 rtl/daes_key_sched_if.sv | 24 ++
 rtl/daes_key_sched.sv | 143 ++++++++++++++
 tb/tb_daes_key_sched.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/daes_key_sched_if.sv
// Handshake bundle between the AES-128 key schedule and its neighbours.
// Carries the key-load handshake, the round-key stream, restart and busy.
// slave: the key schedule block; master: the key source / round-key consumer.
interface daes_key_sched_if;
  logic [127:0] keyin;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         restart;
  logic         busy;

  modport slave (
    input  keyin, key_valid, rk_ready, restart,
    output key_ready, rk_out, rk_round, rk_valid, busy
  );

  modport master (
    output keyin, key_valid, rk_ready, restart,
    input  key_ready, rk_out, rk_round, rk_valid, busy
  );
endinterface

// File: rtl/daes_key_sched.sv
// Purpose: iterative AES-128 key expansion, streams rk[10]..rk[0] for the daes decrypt core.
// Latency: key accept to first round key 10 cycles; 11 beats per stream, replayable via restart.
// Backpressure: rk_out/rk_round held while rk_ready=0; key_ready only in IDLE, new keys wait.
// Ports: clk, rst_n (async active-low), bus (daes_key_sched_if.slave: key in, round keys out,
//        restart, busy).

// Combinational AES forward S-box, one byte.
module daes_key_sched_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Entry 0 sits in the top byte; entry i at bits [(255-i)*8 +: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TBL[{~a, 3'b000} +: 8];
endmodule

module daes_key_sched (
  input  logic             clk,
  input  logic             rst_n,
  daes_key_sched_if.slave  bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [1:0]   state;
  logic [3:0]   idx;
  logic [127:0] rk [0:10];

  logic [127:0] prev_rk;
  logic [127:0] cur_rk;
  logic [127:0] next_rk;
  logic [7:0]   rcon;
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [31:0]  t_w;
  logic [31:0]  w0_n;
  logic [31:0]  w1_n;
  logic [31:0]  w2_n;
  logic [31:0]  w3_n;

  // prev_rk feeds the expansion (rk[idx-1]); cur_rk feeds the stream (rk[idx]).
  always_comb begin
    prev_rk = '0;
    cur_rk  = '0;
    for (int i = 0; i < 11; i++) begin
      if (idx == 4'(i + 1)) prev_rk = rk[i];
      if (idx == 4'(i))     cur_rk  = rk[i];
    end
  end

  // Round constant looked up by round index rather than carried in a shift register.
  always_comb begin
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // RotWord on w3 (the low word), then SubWord through four byte S-boxes.
  assign rot_w = {prev_rk[23:0], prev_rk[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    daes_key_sched_sbox u_sbox (
      .a (rot_w[8*g +: 8]),
      .y (sub_w[8*g +: 8])
    );
  end

  assign t_w     = sub_w ^ {rcon, 24'h0};
  assign w0_n    = prev_rk[127:96] ^ t_w;
  assign w1_n    = prev_rk[95:64]  ^ w0_n;
  assign w2_n    = prev_rk[63:32]  ^ w1_n;
  assign w3_n    = prev_rk[31:0]   ^ w2_n;
  assign next_rk = {w0_n, w1_n, w2_n, w3_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= 4'd0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.key_valid) begin
            rk[0] <= bus.keyin;
            idx   <= 4'd1;
            state <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          for (int i = 1; i < 11; i++) begin
            if (idx == 4'(i)) rk[i] <= next_rk;
          end
          if (idx == 4'd10) begin
            state <= ST_STREAM;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        ST_STREAM: begin
          // restart wins over a same-cycle rk_ready, so round 0 is never retired then.
          if (bus.restart) begin
            idx <= 4'd10;
          end else if (bus.rk_ready) begin
            if (idx == 4'd0) state <= ST_IDLE;
            else             idx   <= idx - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          idx   <= 4'd0;
        end
      endcase
    end
  end

  // All outputs decode registered state only.
  assign bus.key_ready = (state == ST_IDLE);
  assign bus.busy      = (state == ST_EXPAND) || (state == ST_STREAM);
  assign bus.rk_valid  = (state == ST_STREAM);
  assign bus.rk_out    = bus.rk_valid ? cur_rk : '0;
  assign bus.rk_round  = bus.rk_valid ? idx : 4'd0;
endmodule

// File: tb/tb_daes_key_sched.sv
// Directed bench for daes_key_sched: FIPS-197 and all-zero key schedules, backpressure,
// restart, ignored key pulses and asynchronous reset aborts.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_daes_key_sched;
  logic clk = 1'b0;
  logic rst_n;

  daes_key_sched_if bus ();

  daes_key_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] exp_rk    [0:10];
  bit           exp_known [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BAD_KEY  = 128'h00112233445566778899aabbccddeeff;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_fips();
    exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i < 11; i++) exp_known[i] = 1'b1;
  endtask

  task automatic set_zero();
    for (int i = 0; i < 11; i++) begin
      exp_rk[i]    = '0;
      exp_known[i] = 1'b0;
    end
    exp_known[0]  = 1'b1;
    exp_known[1]  = 1'b1;
    exp_known[10] = 1'b1;
    exp_rk[1]     = 128'h62636363626363636263636362636363;
    exp_rk[10]    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  endtask

  task automatic check_reset_outs(input string pfx);
    check({pfx, "_key_ready"}, 128'(bus.key_ready), 128'd1);
    check({pfx, "_rk_valid"},  128'(bus.rk_valid),  128'd0);
    check({pfx, "_rk_out"},    bus.rk_out,          128'd0);
    check({pfx, "_rk_round"},  128'(bus.rk_round),  128'd0);
    check({pfx, "_busy"},      128'(bus.busy),      128'd0);
  endtask

  // Handshake a key, optionally pulse key_valid with another key during EXPAND,
  // and measure accept-to-rk_valid latency.
  task automatic load_key(input logic [127:0] k, input bit inject);
    int lat;
    bus.keyin     = k;
    bus.key_valid = 1'b1;
    check("key_ready_at_load", 128'(bus.key_ready), 128'd1);
    @(negedge clk);
    bus.key_valid = 1'b0;
    check("busy_in_expand", 128'(bus.busy), 128'd1);
    check("key_ready_in_expand", 128'(bus.key_ready), 128'd0);
    lat = 0;
    while (!bus.rk_valid && lat < 40) begin
      if (inject) begin
        bus.keyin     = BAD_KEY;
        bus.key_valid = (lat % 2 == 0);
      end
      @(negedge clk);
      lat++;
    end
    bus.key_valid = 1'b0;
    check("load_latency", 128'(lat), 128'd10);
  endtask

  // Consume rounds 10..0 starting from round 10 currently presented.
  task automatic run_stream(input bit rand_rdy, input bit inject);
    int r;
    int beats;
    int cyc;
    bit rdy;
    r = 10; beats = 0; cyc = 0;
    while (r >= 0 && cyc < 400) begin
      check($sformatf("valid_r%0d", r), 128'(bus.rk_valid), 128'd1);
      check($sformatf("round_r%0d", r), 128'(bus.rk_round), 128'(r));
      if (exp_known[r]) check($sformatf("rk_r%0d", r), bus.rk_out, exp_rk[r]);
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.rk_ready = rdy;
      if (inject) begin
        bus.keyin     = BAD_KEY;
        bus.key_valid = (r > 3) && (cyc % 2 == 1);
      end
      @(negedge clk);
      cyc++;
      if (rdy) begin
        beats++;
        r--;
      end
    end
    bus.rk_ready  = 1'b0;
    bus.key_valid = 1'b0;
    check("stream_in_budget", 128'(cyc < 400), 128'd1);
    check("beat_count", 128'(beats), 128'd11);
    check("rk_valid_after_stream", 128'(bus.rk_valid), 128'd0);
    check("key_ready_after_stream", 128'(bus.key_ready), 128'd1);
    check("busy_after_stream", 128'(bus.busy), 128'd0);
  endtask

  task automatic wait_round(input logic [3:0] want);
    int n;
    n = 0;
    while (bus.rk_round != want && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("reached_round_%0d", want), 128'(bus.rk_round), 128'(want));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.keyin     = '0;
    bus.key_valid = 1'b0;
    bus.rk_ready  = 1'b0;
    bus.restart   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outs("after_reset");

    // FIPS-197 key, consumer always ready
    set_fips();
    load_key(FIPS_KEY, 1'b0);
    run_stream(1'b0, 1'b0);

    // All-zero key
    set_zero();
    load_key('0, 1'b0);
    run_stream(1'b0, 1'b0);

    // Pseudo-random backpressure on the FIPS key
    set_fips();
    load_key(FIPS_KEY, 1'b0);
    run_stream(1'b1, 1'b0);

    // Stray key_valid pulses in EXPAND and STREAM must be ignored
    load_key(FIPS_KEY, 1'b1);
    run_stream(1'b0, 1'b1);

    // Restart mid-stream, then restart together with rk_ready on round 0
    load_key(FIPS_KEY, 1'b0);
    bus.rk_ready = 1'b1;
    wait_round(4'd4);
    bus.rk_ready = 1'b0;
    bus.restart  = 1'b1;
    @(negedge clk);
    bus.restart  = 1'b0;
    check("restart1_round", 128'(bus.rk_round), 128'd10);
    check("restart1_rk", bus.rk_out, exp_rk[10]);
    @(negedge clk);
    check("restart1_hold_round", 128'(bus.rk_round), 128'd10);
    check("restart1_hold_rk", bus.rk_out, exp_rk[10]);
    bus.rk_ready = 1'b1;
    wait_round(4'd0);
    check("round0_rk", bus.rk_out, exp_rk[0]);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart  = 1'b0;
    bus.rk_ready = 1'b0;
    check("restart2_valid", 128'(bus.rk_valid), 128'd1);
    check("restart2_key_ready", 128'(bus.key_ready), 128'd0);
    check("restart2_round", 128'(bus.rk_round), 128'd10);
    check("restart2_rk", bus.rk_out, exp_rk[10]);
    run_stream(1'b0, 1'b0);

    // Async reset mid-EXPAND
    bus.keyin     = FIPS_KEY;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_before_reset", 128'(bus.busy), 128'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("rst_expand");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_reset_outs("idle_after_rst_expand");

    // Async reset mid-STREAM, with no resumption afterwards
    load_key(FIPS_KEY, 1'b0);
    bus.rk_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.rk_ready = 1'b0;
    check("round_before_reset", 128'(bus.rk_round), 128'd7);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("rst_stream");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outs("idle_after_rst_stream");

    // Fresh load after reset yields the full FIPS-197 schedule
    load_key(FIPS_KEY, 1'b0);
    run_stream(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
